// File: rtl/if_id_fetch.sv
// if_id_fetch: instruction-fetch stage and IF/ID pipeline register.
// Holds the PC, drives the instruction-memory address and latches the
// fetched word into ID. The hazard stall and the ID-stage jump redirect
// hold, advance, redirect or squash the front end. Fetch stops once a
// BREAK has been latched, and only reset restarts it.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating stall, flush
// and instruction counters.
module if_id_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000,
  parameter logic [31:0] BREAK_INST = 32'h0000_000D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_inst_cnt,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
  logic        halted_q;

  // Sequential PC step; the 32-bit add wraps 32'hFFFFFFFC to zero.
  function automatic logic [31:0] inc_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  assign pc_d = inc_pc(pc_q);

  // Front-end state machine: PC, IF/ID register and halt flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'd0;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT: begin
          // Give imem one cycle to settle on RESET_PC.
          state_q <= RUN;
        end
        RUN: begin
          if (jump) begin
            // Redirect wins over stall; the wrong-path word is squashed.
            pc_q       <= jump_target;
            id_pc_q    <= 32'd0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
          end else if (!stall) begin
            pc_q       <= pc_d;
            id_pc_q    <= pc_q;
            id_inst_q  <= imem_rdata;
            id_valid_q <= 1'b1;
            if (imem_rdata == BREAK_INST) begin
              state_q <= HALT;
            end
          end
        end
        HALT: begin
          // BREAK stays in ID while stalled; bubbles follow afterwards.
          halted_q <= 1'b1;
          if (!stall) begin
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;
  logic [31:0] inst_cnt_q;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Event counters, active only while fetching in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
      inst_cnt_q  <= 32'd0;
    end else if (state_q == RUN) begin
      if (jump) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end else if (stall) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end else begin
        inst_cnt_q <= sat_inc(inst_cnt_q);
      end
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
  assign perf_inst_cnt  = inst_cnt_q;
`endif

  assign imem_addr = pc_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign id_valid  = id_valid_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_if_id_fetch.sv
// tb_if_id_fetch: directed and random stimulus for if_id_fetch, checked
// against a cycle-level reference model of the fetch front end.
module tb_if_id_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;
  localparam logic [31:0] BREAK_INST = 32'h0000_000D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_inst_cnt;
`endif

  logic [31:0] break_addr = 32'h0000_0001;

  int total = 0;
  int bad   = 0;

  // Model state: mode 0 = just out of reset, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_id_pc, m_id_inst;
  logic        m_valid, m_halted;
  logic [31:0] m_nstall, m_nflush, m_ninst;

  if_id_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump        (jump),
    .jump_target (jump_target),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_inst_cnt  (perf_inst_cnt),
`endif
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory contents; generic words never equal NOP or BREAK.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] brk);
    logic [29:0] h;
    if (a == brk) return BREAK_INST;
    if (a == 32'h0040_0000) return 32'h2008_0001;
    if (a == 32'h0040_0004) return 32'h2009_0002;
    h = a[31:2] ^ 30'h2AAA_AAAA;
    return {h, 2'b10};
  endfunction

  always_comb imem_rdata = mem_word(imem_addr, break_addr);

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input logic r, input logic s, input logic j, input logic [31:0] t);
    logic [31:0] word;
    rst = r; stall = s; jump = j; jump_target = t;
    word = mem_word(m_pc, break_addr);
    @(posedge clk);
    #1;
    if (r) begin
      m_mode = 0; m_pc = RESET_PC; m_id_pc = 0; m_id_inst = NOP_INST;
      m_valid = 0; m_halted = 0; m_nstall = 0; m_nflush = 0; m_ninst = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (j) begin
        m_pc = t; m_id_pc = 0; m_id_inst = NOP_INST; m_valid = 0;
        m_nflush = sat1(m_nflush);
      end else if (s) begin
        m_nstall = sat1(m_nstall);
      end else begin
        m_id_pc = m_pc; m_id_inst = word; m_valid = 1; m_pc = m_pc + 32'd4;
        m_ninst = sat1(m_ninst);
        if (word == BREAK_INST) m_mode = 2;
      end
    end else begin
      m_halted = 1;
      if (!s) begin m_id_inst = NOP_INST; m_valid = 0; end
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("id_pc",     id_pc,     m_id_pc);
    chk("id_inst",   id_inst,   m_id_inst);
    chk("id_valid",  {31'd0, id_valid}, {31'd0, m_valid});
    chk("halted",    {31'd0, halted},   {31'd0, m_halted});
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stall", perf_stall_cnt, m_nstall);
    chk("perf_flush", perf_flush_cnt, m_nflush);
    chk("perf_inst",  perf_inst_cnt,  m_ninst);
`endif
  endtask

  initial begin
    m_mode = 0; m_pc = 0; m_id_pc = 0; m_id_inst = 0; m_valid = 0; m_halted = 0;
    m_nstall = 0; m_nflush = 0; m_ninst = 0;

    // Reset, boot cycle, first two fetches.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("reset_pc", imem_addr, 32'h0040_0000);
    step(0, 1, 1, 32'h1234_5678);       // boot ignores jump and stall
    chk("boot_hold_pc", imem_addr, 32'h0040_0000);
    step(0, 0, 0, 0);
    chk("first_inst", id_inst, 32'h2008_0001);
    chk("first_pc", id_pc, 32'h0040_0000);
    step(0, 0, 0, 0);
    chk("second_inst", id_inst, 32'h2009_0002);

    // Three-cycle stall, then release.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("stall_pc", imem_addr, 32'h0040_0008);
    step(0, 0, 0, 0);
    chk("release_pc", imem_addr, 32'h0040_000C);

    // Jump together with stall squashes and redirects.
    step(0, 1, 1, 32'h0040_0100);
    chk("jump_pc", imem_addr, 32'h0040_0100);
    chk("jump_bubble", {31'd0, id_valid}, 32'd0);
    step(0, 0, 0, 0);
    chk("jump_fetch", id_inst, mem_word(32'h0040_0100, break_addr));

    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc", imem_addr, 32'h0000_0000);

    // Counter scenario: 2 advances, 1 stall, 1 jump after reset.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 32'h0040_0200);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt_inst", perf_inst_cnt, 32'd2);
    chk("cnt_stall", perf_stall_cnt, 32'd1);
    chk("cnt_flush", perf_flush_cnt, 32'd1);
`endif

    // BREAK fetch: one cycle in ID, then halted with frozen PC.
    break_addr = 32'h0040_0008;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("break_in_id", id_inst, BREAK_INST);
    step(0, 0, 0, 0);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 12; i++) step(0, i[0], i[1], 32'h0040_0300);
    chk("halt_pc", imem_addr, 32'h0040_000C);
    step(1, 0, 0, 0);
    chk("halt_reset_pc", imem_addr, 32'h0040_0000);

    // BREAK held in ID under stall, then squashed-path BREAK ignored.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h0040_0400);       // imem shows BREAK but jump squashes it
    step(0, 0, 0, 0);
    chk("squashed_break", {31'd0, halted}, 32'd0);

    // Random traffic with occasional BREAKs and resets.
    break_addr = 32'h0040_0050;
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           32'h0040_0000 + ({27'd0, 5'($urandom_range(0, 31))} << 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
